// File: rtl/lcb_mem_arbiter_pkg.sv
// Shared types and defaults for the LCB-side Orbita buffer arbiter.
package lcb_mem_arbiter_pkg;

    localparam int unsigned DefaultNPorts = 2;
    localparam int unsigned DefaultAw     = 10;  // buffer word address width
    localparam int unsigned DefaultDw     = 12;  // Orbita word width
    localparam int unsigned DefaultRdLat  = 2;   // read enable -> valid read data
    localparam int unsigned AbortCntW     = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWait,
        StWr
    } arb_state_e;

    // Saturating increment for the abort counter.
    function automatic logic [AbortCntW-1:0] sat_inc(input logic [AbortCntW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lcb_mem_arbiter_if.sv
// Requester handshake plus LCB-side buffer port of the Orbita word buffers.
interface lcb_mem_arbiter_if
    import lcb_mem_arbiter_pkg::*;
#(
    parameter int unsigned NPorts = DefaultNPorts,
    parameter int unsigned Aw     = DefaultAw,
    parameter int unsigned Dw     = DefaultDw
);
    // Requester side, port i at [i*W +: W]
    logic [NPorts-1:0]    req;
    logic [NPorts-1:0]    rmw;
    logic [NPorts*Aw-1:0] addr;
    logic [NPorts*Dw-1:0] data;
    logic [NPorts*Dw-1:0] mask;
    logic [NPorts-1:0]    grant;
    logic [NPorts-1:0]    done;

    // Buffer side
    logic [Aw-1:0] rd_addr;
    logic          rd_en;
    logic [Dw-1:0] rd_data;
    logic [Aw-1:0] wr_addr;
    logic [Dw-1:0] wr_data;
    logic          wr_en;

    // Parsers and buffer memory
    modport master (
        output req, rmw, addr, data, mask, rd_data,
        input  grant, done, rd_addr, rd_en, wr_addr, wr_data, wr_en
    );

    // Arbiter
    modport slave (
        input  req, rmw, addr, data, mask, rd_data,
        output grant, done, rd_addr, rd_en, wr_addr, wr_data, wr_en
    );

endinterface

// File: rtl/lcb_mem_arbiter_rr.sv
// Round-robin requester selection; priority starts at the port after the last grantee.
module lcb_mem_arbiter_rr #(
    parameter int unsigned NPorts = 2,
    parameter int unsigned IdxW   = (NPorts > 1) ? $clog2(NPorts) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPorts-1:0] req,
    input  logic              advance,
    output logic [NPorts-1:0] gnt,
    output logic [IdxW-1:0]   gnt_idx,
    output logic              gnt_valid
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    // Scan from the highest-priority port, wrapping, and take the first request.
    always_comb begin
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned i = 0; i < NPorts; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NPorts) cand = cand - NPorts;
            cand_idx = IdxW'(cand);
            if (!gnt_valid && req[cand_idx]) begin
                gnt_valid     = 1'b1;
                gnt_idx       = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

    // Move priority past the port just granted.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = (32'(gnt_idx) == NPorts - 1) ? '0 : gnt_idx + 1'b1;
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/lcb_mem_arbiter.sv
// Serialises LCB parser word updates onto one buffer port, with atomic masked
// read-modify-write and restart of any transaction caught by a bank switch.
module lcb_mem_arbiter
    import lcb_mem_arbiter_pkg::*;
#(
    parameter int unsigned NPorts = DefaultNPorts,
    parameter int unsigned Aw     = DefaultAw,
    parameter int unsigned Dw     = DefaultDw,
    parameter int unsigned RdLat  = DefaultRdLat
) (
    input  logic                 clk,
    input  logic                 reset,
    lcb_mem_arbiter_if.slave     bus,
    input  logic                 switch_i,
    output logic                 bank_o,
    output logic [AbortCntW-1:0] abort_cnt_o
);

    localparam int unsigned IdxW = (NPorts > 1) ? $clog2(NPorts) : 1;
    localparam int unsigned CntW = (RdLat > 1) ? $clog2(RdLat) : 1;

    arb_state_e          state_q, state_d;
    logic                sync1_q, sync2_q;
    logic                bank_q, bank_d;
    logic [AbortCntW-1:0] abort_q, abort_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [Aw-1:0]       addr_q, addr_d;
    logic [Dw-1:0]       data_q, data_d, mask_q, mask_d;
    logic                rmw_q, rmw_d;
    logic [IdxW-1:0]     idx_q, idx_d;

    logic [NPorts-1:0]   grant_q, grant_d, done_q, done_d;
    logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [Aw-1:0]       rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [Dw-1:0]       wr_data_q, wr_data_d;

    logic [NPorts-1:0]   arb_gnt;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_valid, advance;
    logic                sw_edge;

    lcb_mem_arbiter_rr #(
        .NPorts (NPorts),
        .IdxW   (IdxW)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.req),
        .advance   (advance),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign sw_edge = sync2_q != bank_q;

    // Transaction FSM. Strobes are registered, so each appears one cycle after the
    // state that decides it; read data is merged in WR, RdLat cycles after rd_en.
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        abort_d   = abort_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mask_d    = mask_q;
        rmw_d     = rmw_q;
        idx_d     = idx_q;
        advance   = 1'b0;
        grant_d   = '0;
        done_d    = '0;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        unique case (state_q)
            StIdle: begin
                if (sw_edge) begin
                    bank_d = sync2_q;
                end else if (arb_valid) begin
                    addr_d  = bus.addr[arb_idx*Aw +: Aw];
                    data_d  = bus.data[arb_idx*Dw +: Dw];
                    mask_d  = bus.mask[arb_idx*Dw +: Dw];
                    rmw_d   = bus.rmw[arb_idx];
                    idx_d   = arb_idx;
                    advance = 1'b1;
                    grant_d = arb_gnt;
                    state_d = bus.rmw[arb_idx] ? StRd : StWr;
                end
            end
            StRd, StWait, StWr: begin
                if (sw_edge) begin
                    // Restart on the new bank; the latched request is kept.
                    bank_d  = sync2_q;
                    abort_d = sat_inc(abort_q);
                    state_d = rmw_q ? StRd : StWr;
                end else if (state_q == StRd) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    cnt_d     = CntW'(RdLat - 1);
                    state_d   = StWait;
                end else if (state_q == StWait) begin
                    if (cnt_q == '0) state_d = StWr;
                    else             cnt_d   = cnt_q - 1'b1;
                end else begin
                    wr_en_d        = 1'b1;
                    wr_addr_d      = addr_q;
                    wr_data_d      = rmw_q ? ((bus.rd_data & ~mask_q) | (data_q & mask_q))
                                           : data_q;
                    done_d[idx_q]  = 1'b1;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, latched transaction, bank, abort count and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            bank_q    <= 1'b0;
            abort_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            rmw_q     <= 1'b0;
            idx_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= switch_i;
            sync2_q   <= sync1_q;
            bank_q    <= bank_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            rmw_q     <= rmw_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bank_o      = bank_q;
    assign abort_cnt_o = abort_q;

endmodule

// File: tb/tb_lcb_mem_arbiter.sv
// Directed bench for lcb_mem_arbiter with a two-bank buffer model (RdLat = 2).
module tb_lcb_mem_arbiter;

    localparam int unsigned NPorts = 2;
    localparam int unsigned Aw     = 10;
    localparam int unsigned Dw     = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       switch_sig = 1'b0;
    logic       bank;
    logic [7:0] abort_cnt;

    lcb_mem_arbiter_if #(.NPorts(NPorts), .Aw(Aw), .Dw(Dw)) bus ();

    lcb_mem_arbiter #(
        .NPorts (NPorts),
        .Aw     (Aw),
        .Dw     (Dw),
        .RdLat  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .switch_i    (switch_sig),
        .bank_o      (bank),
        .abort_cnt_o (abort_cnt)
    );

    always #5 clk = ~clk;

    // Buffer model: registered address then registered q, per bank.
    logic [Dw-1:0] mem [2][1024];
    logic [Aw-1:0] ra_q;
    logic          rb_q;
    logic [Dw-1:0] rq_q;
    int unsigned   wr_events = 0, done_events = 0, grant_events = 0, overlap = 0;

    assign bus.rd_data = rq_q;

    always @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 1024; i++) mem[b][i] <= '0;
        end else if (bus.wr_en) begin
            mem[bank][bus.wr_addr] <= bus.wr_data;
        end
        if (bus.rd_en) begin
            ra_q <= bus.rd_addr;
            rb_q <= bank;
        end
        rq_q <= mem[rb_q][ra_q];
        if (bus.wr_en) wr_events <= wr_events + 1;
        if (|bus.done) done_events <= done_events + 1;
        if (|bus.grant) grant_events <= grant_events + 1;
        if (bus.rd_en && bus.wr_en) overlap <= overlap + 1;
    end

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic rmw, input logic [Aw-1:0] a,
                            input logic [Dw-1:0] d, input logic [Dw-1:0] m);
        bus.rmw[p]            = rmw;
        bus.addr[p*Aw +: Aw]  = a;
        bus.data[p*Dw +: Dw]  = d;
        bus.mask[p*Dw +: Dw]  = m;
        bus.req[p]            = 1'b1;
    endtask

    task automatic wait_grant(input int p, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.grant[p] && lat < 40);
        check($sformatf("grant_p%0d_seen", p), 32'(bus.grant[p]), 1);
        bus.req[p] = 1'b0;
    endtask

    task automatic wait_wr(input int max, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.wr_en && lat < max);
    endtask

    int lat, lat2, n, p, rem0, rem1, cyc;
    int unsigned base_wr, base_done, base_grant;

    initial begin
        bus.req  = '0;
        bus.rmw  = '0;
        bus.addr = '0;
        bus.data = '0;
        bus.mask = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_rd_en", 32'(bus.rd_en), 0);
        check("rst_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        check("rst_bank", 32'(bank), 0);
        check("rst_abort", 32'(abort_cnt), 0);
        reset = 1'b1;
        @(negedge clk);

        // Plain write, port 0: grant, then write one cycle later
        set_port(0, 1'b0, 10'h005, 12'hABC, 12'h000);
        wait_grant(0, lat);
        check("pw_grant_lat", 32'(lat), 1);
        check("pw_grant_vec", 32'(bus.grant), 32'h1);
        check("pw_wr_early", 32'(bus.wr_en), 0);
        @(negedge clk);
        check("pw_wr_en", 32'(bus.wr_en), 1);
        check("pw_wr_addr", 32'(bus.wr_addr), 32'h005);
        check("pw_wr_data", 32'(bus.wr_data), 32'hABC);
        check("pw_done", 32'(bus.done), 32'h1);
        @(negedge clk);
        check("pw_wr_pulse", 32'(bus.wr_en), 0);

        // Preload 0x123 at 0x010, then RMW from port 1
        set_port(0, 1'b0, 10'h010, 12'h123, 12'h000);
        wait_grant(0, lat);
        wait_wr(10, lat);
        @(negedge clk);
        set_port(1, 1'b1, 10'h010, 12'h0F0, 12'h0F0);
        wait_grant(1, lat);
        check("rmw_rd_early", 32'(bus.rd_en), 0);
        @(negedge clk);
        check("rmw_rd_en", 32'(bus.rd_en), 1);
        check("rmw_rd_addr", 32'(bus.rd_addr), 32'h010);
        wait_wr(20, lat);
        check("rmw_grant_to_wr", 32'(lat + 1), 4);
        check("rmw_wr_addr", 32'(bus.wr_addr), 32'h010);
        check("rmw_wr_data", 32'(bus.wr_data), 32'h1F3);
        check("rmw_done", 32'(bus.done), 32'h2);
        @(negedge clk);

        // Contention: both ports request four writes each; grants must alternate
        set_port(0, 1'b0, 10'h020, 12'h111, 12'h000);
        set_port(1, 1'b0, 10'h021, 12'h222, 12'h000);
        base_wr = wr_events;
        rem0 = 4;
        rem1 = 4;
        n = 0;
        cyc = 0;
        while ((rem0 + rem1) > 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.grant != '0) begin
                p = bus.grant[1] ? 1 : 0;
                check($sformatf("rr_order%0d", n), 32'(p), 32'(n % 2));
                n++;
                if (p == 0) begin
                    rem0--;
                    if (rem0 == 0) bus.req[0] = 1'b0;
                end else begin
                    rem1--;
                    if (rem1 == 0) bus.req[1] = 1'b0;
                end
            end
        end
        check("rr_grant_count", 32'(n), 8);
        repeat (4) @(negedge clk);
        check("rr_wr_count", wr_events - base_wr, 8);
        check("rr_mem_p0", 32'(mem[0][10'h020]), 32'h111);
        check("rr_mem_p1", 32'(mem[0][10'h021]), 32'h222);

        // Bank switch during an RMW: write suppressed, re-read on the new bank
        set_port(0, 1'b0, 10'h030, 12'h555, 12'h000);
        wait_grant(0, lat);
        wait_wr(10, lat);
        @(negedge clk);
        base_wr    = wr_events;
        base_done  = done_events;
        base_grant = grant_events;
        set_port(0, 1'b1, 10'h030, 12'hF00, 12'hF00);
        wait_grant(0, lat);
        @(negedge clk);
        switch_sig = 1'b1;
        lat2 = 0;
        do begin
            @(negedge clk);
            lat2++;
        end while (bank == 1'b0 && lat2 < 10);
        check("sw_bank_delay_ok", 32'(lat2 >= 2 && lat2 <= 3), 1);
        check("sw_bank", 32'(bank), 1);
        check("sw_abort_cnt", 32'(abort_cnt), 1);
        wait_wr(20, lat);
        check("sw_wr_en", 32'(bus.wr_en), 1);
        check("sw_wr_addr", 32'(bus.wr_addr), 32'h030);
        check("sw_wr_data", 32'(bus.wr_data), 32'hF00);
        @(negedge clk);
        check("sw_single_write", wr_events - base_wr, 1);
        check("sw_single_done", done_events - base_done, 1);
        check("sw_single_grant", grant_events - base_grant, 1);
        check("sw_mem_new_bank", 32'(mem[1][10'h030]), 32'hF00);
        check("sw_mem_old_bank", 32'(mem[0][10'h030]), 32'h555);

        // Switching back while idle is not an abort
        switch_sig = 1'b0;
        repeat (5) @(negedge clk);
        check("sw_back_bank", 32'(bank), 0);
        check("sw_back_abort", 32'(abort_cnt), 1);

        // Two ports RMW disjoint nibbles of the same word
        base_done = done_events;
        set_port(0, 1'b1, 10'h000, 12'h005, 12'h00F);
        set_port(1, 1'b1, 10'h000, 12'hA00, 12'hF00);
        cyc = 0;
        while ((done_events - base_done) < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.grant[0]) bus.req[0] = 1'b0;
            if (bus.grant[1]) bus.req[1] = 1'b0;
        end
        check("dual_rmw_done", done_events - base_done, 2);
        @(negedge clk);
        check("dual_rmw_word", 32'(mem[0][10'h000]), 32'hA05);

        // Reset during WAIT abandons the transaction
        set_port(0, 1'b1, 10'h040, 12'hFFF, 12'hFFF);
        wait_grant(0, lat);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(bus.rd_en), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        base_wr = wr_events;
        repeat (10) @(negedge clk);
        check("post_rst_no_write", wr_events - base_wr, 0);
        check("post_rst_wr_en", 32'(bus.wr_en), 0);
        check("post_rst_grant", 32'(bus.grant), 0);
        check("post_rst_done", 32'(bus.done), 0);
        check("post_rst_rd_en", 32'(bus.rd_en), 0);
        check("post_rst_bank", 32'(bank), 0);
        check("post_rst_abort", 32'(abort_cnt), 0);

        check("rd_wr_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
